// File: rtl/ir_pkg.sv
// Shared definitions for the IR key filter: frame field offsets, key entry
// layout, default hold time and error-counter ceiling.
package ir_pkg;

   localparam int unsigned ADDR_LO = 0;
   localparam int unsigned ADDR_HI = 8;
   localparam int unsigned CMD     = 16;
   localparam int unsigned CMD_N   = 24;

   localparam int unsigned HOLD_TICKS_DEF = 1800000;
   localparam logic [7:0]  ERR_MAX        = 8'hFF;

   typedef struct packed {
      logic        is_repeat;
      logic [15:0] addr;
      logic [7:0]  cmd;
   } ir_key_t;

   // Extract one byte field of an NEC frame at the given bit offset.
   function automatic logic [7:0] frame_byte(input logic [31:0] f, input int unsigned off);
      return f[off +: 8];
   endfunction

endpackage

// File: rtl/ir_key_filter_if.sv
// Key handshake toward the command consumer.
// master: filter side (drives head and valid); slave: consumer side.
interface ir_key_filter_if;
   logic        key_valid;
   logic        key_ready;
   logic [7:0]  key_cmd;
   logic [15:0] key_addr;
   logic        key_repeat;

   modport master (
      output key_valid,
      output key_cmd,
      output key_addr,
      output key_repeat,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_cmd,
      input  key_addr,
      input  key_repeat,
      output key_ready
   );
endinterface

// File: rtl/ir_key_fifo.sv
// Synchronous FIFO of ir_key_t entries with a registered head.
// A push while full with no pop is dropped; push+pop when full both occur.
// When empty the head register keeps the last value it held.
module ir_key_fifo
   import ir_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  ir_key_t push_data,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output ir_key_t head
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   ir_key_t       mem_q [DEPTH];
   ir_key_t       mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;
   ir_key_t       head_q, head_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = head_q;

   // Next pointers, occupancy, storage and head register.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);

      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end

      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // Incoming entry becomes head when nothing older survives this cycle;
      // otherwise the head follows the read pointer.
      if (do_push && (empty || (cnt_q == (PW+1)'(1) && do_pop))) begin
         head_d = push_data;
      end else if (cnt_d != '0) begin
         head_d = mem_q[rd_d];
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ir_key_filter.sv
// NEC key filter: captures decoder frames, validates complement fields,
// tags repeats, buffers keys in a FIFO and tracks key-hold time.
// Build option: define IR_EXT_ADDR_EN for extended (16-bit) NEC addressing.
module ir_key_filter
   import ir_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
   parameter int unsigned TW         = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     frame_valid,
   input  logic [31:0]              frame,
   ir_key_filter_if.master          key_if,
   output logic                     key_held,
   output logic [7:0]               err_count,
   output logic                     overflow
);

   logic          cap_v_q, cap_v_d;
   logic [31:0]   cap_f_q, cap_f_d;
   logic [23:0]   last_q, last_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          held_q, held_d;
   logic [7:0]    err_q, err_d;
   logic          overflow_q, overflow_d;

   logic [7:0]    addr_lo, addr_hi, cmd_b, cmd_n;
   logic [15:0]   addr16;
   logic          cmd_ok, addr_ok, accept;
   ir_key_t       push_key;
   logic          fifo_full, fifo_empty, pop;
   ir_key_t       head;

   // Stage 1: capture a frame on an enabled strobe.
   always_comb begin
      cap_v_d = enable & frame_valid;
      cap_f_d = cap_v_d ? frame : cap_f_q;
   end

   // Stage 2: validate fields, build entry, update last key and error count.
   always_comb begin
      addr_lo = frame_byte(cap_f_q, ADDR_LO);
      addr_hi = frame_byte(cap_f_q, ADDR_HI);
      cmd_b   = frame_byte(cap_f_q, CMD);
      cmd_n   = frame_byte(cap_f_q, CMD_N);
      cmd_ok  = (cmd_n == ~cmd_b);
`ifdef IR_EXT_ADDR_EN
      addr_ok = 1'b1;
      addr16  = {addr_hi, addr_lo};
`else
      addr_ok = (addr_hi == ~addr_lo);
      addr16  = {8'h00, addr_lo};
`endif
      accept             = cap_v_q & cmd_ok & addr_ok;
      push_key.is_repeat = held_q & ({addr16, cmd_b} == last_q);
      push_key.addr      = addr16;
      push_key.cmd       = cmd_b;

      last_d = accept ? {addr16, cmd_b} : last_q;
      err_d  = err_q;
      if (cap_v_q && !accept && err_q != ERR_MAX) begin
         err_d = err_q + 8'd1;
      end
   end

   // Hold timer: restarts on accept, counts enable ticks until saturation.
   always_comb begin
      timer_d = timer_q;
      held_d  = held_q;
      if (accept) begin
         timer_d = '0;
         held_d  = 1'b1;
      end else if (held_q && enable) begin
         timer_d = timer_q + 1'b1;
         held_d  = (timer_d < TW'(HOLD_TICKS));
      end
   end

   // Sticky overflow when an accepted key meets a full FIFO with no pop.
   always_comb begin
      pop        = ~fifo_empty & key_if.key_ready;
      overflow_d = overflow_q | (accept & fifo_full & ~pop);
   end

   // Pipeline, hold and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_v_q    <= 1'b0;
         cap_f_q    <= '0;
         last_q     <= '0;
         timer_q    <= '0;
         held_q     <= 1'b0;
         err_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         cap_v_q    <= cap_v_d;
         cap_f_q    <= cap_f_d;
         last_q     <= last_d;
         timer_q    <= timer_d;
         held_q     <= held_d;
         err_q      <= err_d;
         overflow_q <= overflow_d;
      end
   end

   ir_key_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (push_key),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign key_if.key_valid  = ~fifo_empty;
   assign key_if.key_cmd    = head.cmd;
   assign key_if.key_addr   = head.addr;
   assign key_if.key_repeat = head.is_repeat;
   assign key_held          = held_q;
   assign err_count         = err_q;
   assign overflow          = overflow_q;

endmodule

// File: tb/tb_ir_key_filter.sv
// Bench for ir_key_filter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_ir_key_filter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLD  = 40;
   localparam int unsigned TW    = 8;
`ifdef IR_EXT_ADDR_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        frame_valid;
   logic [31:0] frame;
   logic        key_held;
   logic [7:0]  err_count;
   logic        overflow;

   ir_key_filter_if key_if ();

   ir_key_filter #(
      .DEPTH      (DEPTH),
      .HOLD_TICKS (HOLD),
      .TW         (TW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .frame_valid (frame_valid),
      .frame       (frame),
      .key_if      (key_if),
      .key_held    (key_held),
      .err_count   (err_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: a queue of pending keys {repeat, addr16, cmd}.
   logic [24:0] mq[$];
   logic [24:0] m_head;
   logic [23:0] m_last;
   int          m_ticks;
   bit          m_held;
   int          m_err;
   bit          m_ovf;
   bit          m_pend;
   logic [31:0] m_pf;

   // Advance the model by one clock edge using the inputs about to be sampled.
   task automatic model_edge();
      bit          acc;
      logic [24:0] ent;
      logic [7:0]  alo, ahi, c, cn;
      logic [15:0] a16;
      acc = 1'b0;
      ent = '0;
      if (rst) begin
         mq.delete();
         m_head  = '0;
         m_last  = '0;
         m_ticks = 0;
         m_held  = 1'b0;
         m_err   = 0;
         m_ovf   = 1'b0;
         m_pend  = 1'b0;
         m_pf    = '0;
      end else begin
         if (m_pend) begin
            alo = m_pf[7:0];
            ahi = m_pf[15:8];
            c   = m_pf[23:16];
            cn  = m_pf[31:24];
            if (((c ^ cn) == 8'hFF) && (EXT || ((alo ^ ahi) == 8'hFF))) begin
               a16    = EXT ? {ahi, alo} : {8'h00, alo};
               ent    = {(m_held && ({a16, c} == m_last)), a16, c};
               m_last = {a16, c};
               acc    = 1'b1;
            end else if (m_err < 255) begin
               m_err++;
            end
         end
         if (mq.size() > 0 && key_if.key_ready) void'(mq.pop_front());
         if (acc) begin
            if (mq.size() < DEPTH) mq.push_back(ent);
            else m_ovf = 1'b1;
         end
         if (acc) begin
            m_ticks = 0;
            m_held  = 1'b1;
         end else if (m_held && enable) begin
            m_ticks++;
            if (m_ticks >= HOLD) m_held = 1'b0;
         end
         if (mq.size() > 0) m_head = mq[0];
         m_pend = enable && frame_valid;
         m_pf   = frame;
      end
   endtask

   task automatic compare_all();
      check_eq("key_valid",  key_if.key_valid, 32'(mq.size() != 0));
      check_eq("key_cmd",    key_if.key_cmd, m_head[7:0]);
      check_eq("key_addr",   key_if.key_addr, m_head[23:8]);
      check_eq("key_repeat", key_if.key_repeat, m_head[24]);
      check_eq("key_held",   key_held, m_held);
      check_eq("err_count",  err_count, m_err);
      check_eq("overflow",   overflow, m_ovf);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_frame(input logic [31:0] f);
      frame_valid = 1'b1;
      frame       = f;
      tick();
      frame_valid = 1'b0;
   endtask

   function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction

   function automatic logic [31:0] rand_frame();
      logic [7:0]  pa[3];
      logic [7:0]  pc[3];
      logic [31:0] f;
      pa[0] = 8'h04; pa[1] = 8'h12; pa[2] = 8'h80;
      pc[0] = 8'h08; pc[1] = 8'h15; pc[2] = 8'h44;
      f = nec(pa[$urandom_range(2, 0)], pc[$urandom_range(2, 0)]);
      if ($urandom_range(4, 0) == 0) f = f ^ (32'h1 << $urandom_range(31, 0));
      if ($urandom_range(5, 0) == 0) f[15:8] = 8'($urandom);
      return f;
   endfunction

   int pre_err;
   bit prev_fv;

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      frame_valid = 1'b0;
      frame       = '0;
      key_if.key_ready = 1'b1;
      idle(2);
      check_eq("rst_valid", key_if.key_valid, 0);
      check_eq("rst_held", key_held, 0);
      rst    = 1'b0;
      enable = 1'b1;
      idle(2);

      // First valid key: visible two cycles after the strobe.
      send_frame(32'hF708_FB04);
      check_eq("lat_n1_valid", key_if.key_valid, 0);
      tick();
      check_eq("lat_valid", key_if.key_valid, 1);
      check_eq("lat_addr", key_if.key_addr, 16'h0004);
      check_eq("lat_cmd", key_if.key_cmd, 8'h08);
      check_eq("lat_rpt", key_if.key_repeat, 0);
      check_eq("lat_held", key_held, 1);
      idle(30);

      // Same key while held -> repeat.
      send_frame(32'hF708_FB04);
      tick();
      check_eq("rpt_flag", key_if.key_repeat, 1);
      idle(HOLD + 10);
      check_eq("hold_drop", key_held, 0);
      send_frame(32'hF708_FB04);
      tick();
      check_eq("rpt_after_release", key_if.key_repeat, 0);
      idle(3);

      // Bad command complement.
      pre_err = err_count;
      send_frame(32'hF608_FB04);
      tick();
      check_eq("badcmd_err", err_count, pre_err + 1);
      check_eq("badcmd_valid", key_if.key_valid, 0);

      // Address high byte that is not the complement.
      pre_err = err_count;
      send_frame(32'hF708_1234);
      tick();
      check_eq("ext_err", err_count, EXT ? pre_err : pre_err + 1);
      if (EXT) check_eq("ext_addr", key_if.key_addr, 16'h1234);
      idle(3);

      // Stall consumer, overfill by one, then drain in order.
      key_if.key_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_frame(nec(8'h04, 8'(8'h10 + i)));
         tick();
      end
      idle(2);
      check_eq("ovf_set", overflow, 1);
      key_if.key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_cmd", key_if.key_cmd, 8'h10 + i);
         tick();
      end
      check_eq("drain_empty", key_if.key_valid, 0);

      // Saturating error counter.
      for (int i = 0; i < 260; i++) send_frame(32'hF608_FB04);
      idle(2);
      check_eq("err_sat", err_count, 255);

      // Reset while a captured frame is in flight.
      send_frame(32'hF708_FB04);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstfl_valid", key_if.key_valid, 0);
      check_eq("rstfl_cmd", key_if.key_cmd, 0);
      check_eq("rstfl_held", key_held, 0);
      check_eq("rstfl_err", err_count, 0);
      check_eq("rstfl_ovf", overflow, 0);
      idle(4);
      check_eq("rstfl_nokey", key_if.key_valid, 0);

      // Random traffic.
      prev_fv = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         enable           = ($urandom_range(3, 0) != 0);
         key_if.key_ready = ($urandom_range(2, 0) != 0);
         frame_valid      = !prev_fv && ($urandom_range(4, 0) == 0);
         frame            = rand_frame();
         rst              = ($urandom_range(799, 0) == 0);
         prev_fv          = frame_valid;
         tick();
      end
      rst         = 1'b0;
      frame_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_key_filter.md
Name: ir_key_filter

Overview:
- Sits directly downstream of the IR frame decoder and consumes its 32-bit NEC frame plus one-cycle frame strobe.
- Validates the address/command complement fields and classifies each valid frame as a new key press or an auto-repeat.
- Buffers valid keys in a small FIFO with a valid/ready handshake toward the command consumer (UI/register block).
- Counts rejected frames and tracks key-hold state with a tick-driven timeout.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HOLD_TICKS, 1800000, enable ticks after the last accepted frame before a key counts as released.
- TW, 24, hold-timer width; must satisfy HOLD_TICKS < 2**TW.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  timebase tick shared with the decoder; gates frame capture and the hold timer.
- frame_valid  in  1  decoder strobe, one cycle wide; frame is stable while high.
- frame  in  32  NEC frame, LSB-first: [7:0] addr, [15:8] ~addr or addr_hi, [23:16] cmd, [31:24] ~cmd.
- key_valid  out  1  FIFO head valid.
- key_ready  in  1  consumer accepts head.
- key_cmd  out  8  head command.
- key_addr  out  16  head address.
- key_repeat  out  1  head is a repeat of the previous accepted key.
- key_held  out  1  high while hold timer < HOLD_TICKS since the last accepted frame.
- err_count  out  8  rejected-frame count, saturating.
- overflow  out  1  sticky; a valid key was dropped because the FIFO was full.

Behaviour:
- Reset: a synchronous, active-high rst clears key_valid, key_cmd, key_addr, key_repeat, key_held, err_count, overflow, the FIFO pointers, the hold timer, the last-key register and the pipeline stage. An in-flight frame is discarded.
- Stage 1 (capture): when enable=1 and frame_valid=1, register frame and set stage1_v for exactly one cycle. frame_valid with enable=0 is ignored.
- Stage 2 (check), in the cycle after capture:
  - cmd_ok = (f[31:24] == ~f[23:16]).
  - addr_ok = (f[15:8] == ~f[7:0]); see Optional Feature.
  - Both ok: build entry {repeat, addr16, cmd}. addr16 = {8'h00, f[7:0]}, or {f[15:8], f[7:0]} with the macro.
    - repeat = 1 iff key_held=1 and {addr16, cmd} equals the last accepted key.
    - Push the entry, update the last-key register, clear the hold timer to 0, set key_held=1.
  - Otherwise: err_count += 1, saturating at 255. No push, timer unaffected.
- Latency: frame_valid at cycle N → push at N+2 → key_valid high at N+2 if the FIFO was empty. Outputs are registered from the FIFO head.
- Hold timer: increments on each enable tick while < HOLD_TICKS, then saturates. key_held drops in the same cycle the timer reaches HOLD_TICKS. The timer is idle after reset until the first accepted key.
- FIFO:
  - Pop when key_valid & key_ready.
  - Push while full with no pop: drop the entry, set overflow. Pointers unchanged.
  - Push and pop in the same cycle, including when full: both occur and occupancy is unchanged.
  - Empty: key_valid=0. key_cmd/key_addr/key_repeat hold their last value and must not be interpreted.
- Handshake rule: consumer side is ungated by enable. key_valid, once high, stays high with a stable head until popped.
- Simultaneous accept and timer saturation in the same cycle: accept wins, timer=0, key_held=1.

Optional Feature:
- Macro: IR_EXT_ADDR_EN.
- Defined: extended NEC addressing. The addr_ok check is skipped, and key_addr = {f[15:8], f[7:0]}.
- Undefined: standard NEC. A frame fails when f[15:8] != ~f[7:0], and key_addr[15:8] = 0.

Decomposition:
- Package ir_pkg:
  - frame field offsets (ADDR_LO, ADDR_HI, CMD, CMD_N).
  - key entry typedef ir_key_t {repeat, addr[15:0], cmd[7:0]}.
  - default HOLD_TICKS.
  - ERR_MAX = 8'hFF.
- Sub-module ir_key_fifo: generic synchronous FIFO of ir_key_t with DEPTH, push/pop, full/empty and drop-on-full.

Test Plan:
- Valid standard frame 32'hF708_FB04 (addr 04, cmd 08), key_ready=1 → key_valid pulse at N+2; key_addr=16'h0004, key_cmd=8'h08, key_repeat=0, key_held=1.
- Same frame again 1000 ticks later → key_repeat=1. Again after HOLD_TICKS+10 ticks → key_held already low; key_repeat=0.
- Bad cmd complement 32'hF608_FB04 → no push; err_count increments. 260 bad frames → err_count=255.
- key_ready=0, five valid frames (DEPTH=4) → first four retained in order, fifth dropped, overflow=1. Then pop all four → keys in order, key_valid=0.
- Frame 32'hF708_1234 → rejected without IR_EXT_ADDR_EN; with it, key_addr=16'h1234.
- rst asserted the cycle after frame_valid → no key ever appears; all outputs 0 the following cycle.
